// File: rtl/oled_spi_arbiter.sv
// Round-robin arbiter that shares one spi_controller and the OLED DC pin
// between several byte-stream requesters. A grant is held for a whole burst.
// Each byte carries its own DC value. A DC change inserts a setup delay
// before the byte is offered to the SPI controller.
module oled_spi_arbiter #(
    parameter int NUM_REQ         = 3,
    parameter int DC_SETUP_CYCLES = 4
) (
    input  logic                   sysClkIn,
    input  logic                   sysRstIn,
    input  logic [NUM_REQ-1:0]     reqValidIn,
    output logic [NUM_REQ-1:0]     reqReadyOut,
    input  logic [8*NUM_REQ-1:0]   reqDataIn,
    input  logic [NUM_REQ-1:0]     reqDcIn,
    input  logic [NUM_REQ-1:0]     reqLastIn,
    output logic [NUM_REQ-1:0]     grantOut,
    output logic                   busyOut,
    output logic [15:0]            burstCntOut,
    output logic                   spiValidOut,
    input  logic                   spiReadyIn,
    output logic [7:0]             spiDataOut,
    output logic                   DC
);

    localparam int PTR_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int SETUP_W    = (DC_SETUP_CYCLES > 1) ? $clog2(DC_SETUP_CYCLES) : 1;
    localparam int SETUP_LAST = (DC_SETUP_CYCLES > 0) ? DC_SETUP_CYCLES - 1 : 0;

    typedef enum logic [2:0] {
        IDLE,
        ACCEPT,
        SETUP,
        SEND,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [PTR_W-1:0]     gnt_idx_q, gnt_idx_d;
    logic [PTR_W-1:0]     rr_q, rr_d;
    logic [15:0]          cnt_q, cnt_d;
    logic [7:0]           data_q, data_d;
    logic                 last_q, last_d;
    logic                 dc_q, dc_d;
    logic                 valid_q, valid_d;
    logic [SETUP_W-1:0]   setup_q, setup_d;

    logic                 sel_valid;
    logic [7:0]           sel_data;
    logic                 sel_dc;
    logic                 sel_last;

    logic                 arb_found;
    logic [PTR_W-1:0]     arb_idx;
    logic [NUM_REQ-1:0]   arb_onehot;

    // Select the byte, DC and last flag of the current grant holder
    always_comb begin
        sel_valid = 1'b0;
        sel_data  = '0;
        sel_dc    = 1'b0;
        sel_last  = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_q[i]) begin
                sel_valid = reqValidIn[i];
                sel_data  = reqDataIn[i*8 +: 8];
                sel_dc    = reqDcIn[i];
                sel_last  = reqLastIn[i];
            end
        end
    end

    // Round-robin search: first requesting index after rr_q, with wrap-around
    always_comb begin
        arb_found  = 1'b0;
        arb_idx    = '0;
        arb_onehot = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (!arb_found && reqValidIn[i] &&
                    (((32'(rr_q) + k) % NUM_REQ) == i)) begin
                    arb_found     = 1'b1;
                    arb_idx       = PTR_W'(i);
                    arb_onehot    = '0;
                    arb_onehot[i] = 1'b1;
                end
            end
        end
    end

    // Next-state and datapath updates for the burst FSM
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        gnt_idx_d = gnt_idx_q;
        rr_d      = rr_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        last_d    = last_q;
        dc_d      = dc_q;
        valid_d   = 1'b0;
        setup_d   = setup_q;
        case (state_q)
            IDLE: begin
                if (arb_found) begin
                    grant_d   = arb_onehot;
                    gnt_idx_d = arb_idx;
                    cnt_d     = '0;
                    state_d   = ACCEPT;
                end
            end
            ACCEPT: begin
                if (sel_valid) begin
                    data_d = sel_data;
                    last_d = sel_last;
                    if (sel_dc != dc_q) begin
                        dc_d    = sel_dc;
                        setup_d = '0;
                        state_d = (DC_SETUP_CYCLES == 0) ? SEND : SETUP;
                    end else begin
                        state_d = SEND;
                    end
                end
            end
            SETUP: begin
                if (setup_q == SETUP_W'(SETUP_LAST)) begin
                    state_d = SEND;
                end else begin
                    setup_d = setup_q + 1'b1;
                end
            end
            SEND: begin
                if (spiReadyIn) begin
                    valid_d = 1'b1;
                    state_d = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                if (!spiReadyIn) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (spiReadyIn) begin
                    if (cnt_q != 16'hFFFF) begin
                        cnt_d = cnt_q + 16'd1;
                    end
                    if (last_q) begin
                        rr_d    = gnt_idx_q;
                        grant_d = '0;
                        state_d = IDLE;
                    end else begin
                        state_d = ACCEPT;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge sysClkIn) begin
        if (sysRstIn) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            gnt_idx_q <= '0;
            rr_q      <= PTR_W'(NUM_REQ - 1);
            cnt_q     <= '0;
            data_q    <= '0;
            last_q    <= 1'b0;
            dc_q      <= 1'b0;
            valid_q   <= 1'b0;
            setup_q   <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            gnt_idx_q <= gnt_idx_d;
            rr_q      <= rr_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            last_q    <= last_d;
            dc_q      <= dc_d;
            valid_q   <= valid_d;
            setup_q   <= setup_d;
        end
    end

    assign reqReadyOut = (state_q == ACCEPT) ? grant_q : '0;
    assign grantOut    = grant_q;
    assign busyOut     = (state_q != IDLE);
    assign burstCntOut = cnt_q;
    assign spiValidOut = valid_q;
    assign spiDataOut  = data_q;
    assign DC          = dc_q;

endmodule
